led_pattern_sequencer: RTL and testbench
========================================

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 4: clock cycles per step tick, legal range 1..2^24.
REQ-002 SHALL have parameter STEPS_PER_MODE, default 12: ticks spent in each pattern mode, legal range 2..256.
REQ-003 SHALL have parameter NUM_LEDS, default 8: LED output width, legal range 2..32.
REQ-004 SHALL have port i_clk, input, 1 bit: sole clock; all logic is rising-edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port i_en, input, 1 bit: run enable; low freezes all state.
REQ-007 SHALL have port i_hold, input, 1 bit: when high, repeat the current mode instead of advancing.
REQ-008 SHALL have port o_led, output, NUM_LEDS bits: registered LED pattern.
REQ-009 SHALL have port o_mode, output, 3 bits: registered state encoding (IDLE=0, COUNT=1, WALK=2, BLINK=3, GAP=4).
REQ-010 SHALL have port o_tick, output, 1 bit: step strobe, high exactly when i_en=1 and pre_cnt=PRESCALE-1.

Function
REQ-011 SHALL keep prescaler pre_cnt, width $clog2(PRESCALE) with a minimum of 1; +1 per cycle with i_en=1; wraps PRESCALE-1 -> 0; holds when i_en=0.
REQ-012 SHALL treat PRESCALE=1 as o_tick=i_en every cycle.
REQ-013 SHALL perform all step and state updates only on an edge where o_tick=1.
REQ-014 SHALL on a tick in IDLE go to COUNT with step=0.
REQ-015 SHALL keep step counter 0..STEPS_PER_MODE-1; +1 per tick; on a tick at STEPS_PER_MODE-1, step -> 0 and mode advances COUNT->WALK->BLINK->GAP->COUNT.
REQ-016 SHALL when i_hold=1 on a wrapping tick set step -> 0 and keep the mode; i_hold is ignored on non-wrapping ticks.
REQ-017 SHALL drive o_led = pattern(mode, step) at all times, registered with no combinational path from inputs to o_led.
REQ-018 SHALL use patterns: IDLE all 0; COUNT = step zero-extended or truncated to NUM_LEDS; WALK = 1 << (step mod NUM_LEDS); BLINK all 1 on even step, all 0 on odd step; GAP all 0.
REQ-019 SHALL when i_en falls mid-count hold pre_cnt, step, mode and o_led, and resume from the same pre_cnt on re-enable.

Reset
REQ-020 SHALL on an edge with i_rst_n=0 set pre_cnt=0, step=0, mode=IDLE, o_led=0, with priority over i_en and o_tick.
REQ-021 SHALL hold o_tick=0 while i_rst_n=0 and in the cycle it is released, unless PRESCALE=1 and i_en=1.
REQ-022 SHALL on reset asserted mid-mode restart at IDLE; no partial state is retained.

Configuration
REQ-023 SHALL when LED_SEQ_GAP_EN is defined include the GAP state exactly as specified above.
REQ-024 SHALL when LED_SEQ_GAP_EN is undefined remove the GAP state: BLINK wraps to COUNT, and o_mode never reports 4.

Structure
REQ-025 SHALL place the state enum (3-bit), mode encodings and pattern constants in package led_seq_pkg.
REQ-026 SHALL implement the prescaler as sub-module led_seq_tick_gen (params PRESCALE; ports i_clk, i_rst_n, i_en, o_tick).
REQ-027 SHALL keep the step counter, FSM and pattern register in led_pattern_sequencer.

Verification (PRESCALE=4, STEPS_PER_MODE=12, NUM_LEDS=8, GAP enabled unless stated)
REQ-028 SHALL cover: release reset with i_en=1 -> o_tick high on the 4th cycle, then every 4; mode IDLE->COUNT, o_led=0x00.
REQ-029 SHALL cover: run 12 ticks in COUNT -> o_led 0x00..0x0B, then WALK 0x01,0x02..0x80,0x01..0x08, then BLINK FF/00 alternating, then GAP 0x00 for 12 ticks, then back to COUNT.
REQ-030 SHALL cover: i_hold=1 across the COUNT wrap tick -> step 0, o_mode stays 1, o_led=0x00.
REQ-031 SHALL cover: i_en low for 10 cycles at pre_cnt=2 mid-WALK -> o_led, o_mode and o_tick frozen; first tick 1 cycle after re-enable.
REQ-032 SHALL cover: i_rst_n low for 1 cycle coinciding with a tick in BLINK -> next cycle o_mode=0, o_led=0x00, pre_cnt=0.
REQ-033 SHALL cover: LED_SEQ_GAP_EN undefined -> after BLINK step 11, o_mode goes 3->1 and o_mode=4 never occurs; also PRESCALE=1 gives o_tick=i_en.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
// Optional feature macro: LED_SEQ_GAP_EN (adds the all-dark GAP mode after BLINK).
package led_seq_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE  = 3'd0,
    MODE_COUNT = 3'd1,
    MODE_WALK  = 3'd2,
`ifdef LED_SEQ_GAP_EN
    MODE_BLINK = 3'd3,
    MODE_GAP   = 3'd4
`else
    MODE_BLINK = 3'd3
`endif
  } mode_e;

  // BLINK lights every LED on steps whose LSB matches this parity (even steps).
  localparam logic BLINK_ON_PARITY = 1'b0;

  // Mode rotation applied on a wrapping tick.
  function automatic mode_e mode_after(input mode_e m);
    mode_e n;
    case (m)
      MODE_COUNT: n = MODE_WALK;
      MODE_WALK:  n = MODE_BLINK;
`ifdef LED_SEQ_GAP_EN
      MODE_BLINK: n = MODE_GAP;
      MODE_GAP:   n = MODE_COUNT;
`else
      MODE_BLINK: n = MODE_COUNT;
`endif
      default:    n = MODE_COUNT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/led_seq_tick_gen.sv
// Step-tick prescaler: strobes once every PRESCALE enabled cycles.
module led_seq_tick_gen #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;

  // Prescale counter: advances only while enabled, wraps at PRESCALE-1.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pre_cnt <= '0;
    end else if (i_en) begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
    end
  end

  // With PRESCALE=1 every enabled cycle is a tick, even during reset;
  // otherwise reset masks the strobe so a stale count cannot fire it.
  assign o_tick = i_en & ((PRESCALE == 1) | (i_rst_n & (pre_cnt == PRE_LAST)));

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: IDLE -> COUNT -> WALK -> BLINK [-> GAP] -> COUNT ...
// Optional feature macro: LED_SEQ_GAP_EN (enables the GAP mode).
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned PRESCALE       = 4,
  parameter int unsigned STEPS_PER_MODE = 12,
  parameter int unsigned NUM_LEDS       = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_hold,
  output logic [NUM_LEDS-1:0] o_led,
  output logic [2:0]          o_mode,
  output logic                o_tick
);

  localparam int unsigned STEP_W = (STEPS_PER_MODE > 1) ? $clog2(STEPS_PER_MODE) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS_PER_MODE - 1);

  mode_e             state;
  mode_e             nxt_state;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] nxt_step;
  logic              tick;

  led_seq_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_en),
    .o_tick (tick)
  );

  assign o_tick = tick;
  assign o_mode = state;

  function automatic logic [NUM_LEDS-1:0] led_pattern(input mode_e m, input logic [STEP_W-1:0] s);
    logic [NUM_LEDS-1:0] p;
    p = '0;
    case (m)
      MODE_COUNT: p = NUM_LEDS'(s);
      MODE_WALK:  p = NUM_LEDS'(1) << (int'(s) % NUM_LEDS);
      MODE_BLINK: p = (s[0] == BLINK_ON_PARITY) ? '1 : '0;
      default:    p = '0;
    endcase
    return p;
  endfunction

  // Next mode/step as they would be after a tick; hold only matters on a wrap.
  always_comb begin
    nxt_state = state;
    nxt_step  = step;
    if (state == MODE_IDLE) begin
      nxt_state = MODE_COUNT;
      nxt_step  = '0;
    end else if (step == STEP_LAST) begin
      nxt_step = '0;
      if (!i_hold) nxt_state = mode_after(state);
    end else begin
      nxt_step = step + 1'b1;
    end
  end

  // FSM, step counter and LED register all advance together on a tick.
  // o_led is loaded from the next mode/step so it always matches the registered pair.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= MODE_IDLE;
      step  <= '0;
      o_led <= '0;
    end else if (tick) begin
      state <= nxt_state;
      step  <= nxt_step;
      o_led <= led_pattern(nxt_state, nxt_step);
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench: two sequencer instances against a behavioural model.
module tb_led_pattern_sequencer;

  // Instance A: default parameters. Instance B: PRESCALE=1, short modes, 2 LEDs.
  localparam int PA = 4, SA = 12, NA = 8;
  localparam int PB = 1, SB = 6,  NB = 2;
`ifdef LED_SEQ_GAP_EN
  localparam int LAST_MODE = 4;
`else
  localparam int LAST_MODE = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, en_a = 1'b0, hold_a = 1'b0;
  logic rst_b = 1'b0, en_b = 1'b0, hold_b = 1'b0;
  logic [NA-1:0] led_a;
  logic [NB-1:0] led_b;
  logic [2:0]    mode_a, mode_b;
  logic          tick_a, tick_b;

  led_pattern_sequencer #(.PRESCALE(PA), .STEPS_PER_MODE(SA), .NUM_LEDS(NA)) dut_a (
    .i_clk(clk), .i_rst_n(rst_a), .i_en(en_a), .i_hold(hold_a),
    .o_led(led_a), .o_mode(mode_a), .o_tick(tick_a)
  );

  led_pattern_sequencer #(.PRESCALE(PB), .STEPS_PER_MODE(SB), .NUM_LEDS(NB)) dut_b (
    .i_clk(clk), .i_rst_n(rst_b), .i_en(en_b), .i_hold(hold_b),
    .o_led(led_b), .o_mode(mode_b), .o_tick(tick_b)
  );

  typedef struct {
    int pre;
    int step;
    int mode;
  } mdl_t;

  mdl_t ma = '{0, 0, 0};
  mdl_t mb = '{0, 0, 0};
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   b_live   = 1'b0;
  logic tick_seen_a;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit mdl_tick(input mdl_t m, input int p, input bit rst, input bit en);
    return en && (p == 1 || (rst && m.pre == p - 1));
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input int p, input int s,
                                    input bit rst, input bit en, input bit hold);
    mdl_t r;
    bit   t;
    r = m;
    t = mdl_tick(m, p, rst, en);
    if (!rst) begin
      r = '{0, 0, 0};
    end else if (en) begin
      r.pre = (m.pre + 1) % p;
      if (t) begin
        if (m.mode == 0) begin
          r.mode = 1;
          r.step = 0;
        end else if (m.step == s - 1) begin
          r.step = 0;
          if (!hold) r.mode = (m.mode == LAST_MODE) ? 1 : m.mode + 1;
        end else begin
          r.step = m.step + 1;
        end
      end
    end
    return r;
  endfunction

  function automatic int mdl_led(input mdl_t m, input int n);
    int mask;
    mask = (1 << n) - 1;
    case (m.mode)
      1:       return m.step & mask;
      2:       return 1 << (m.step % n);
      3:       return (m.step % 2 == 0) ? mask : 0;
      default: return 0;
    endcase
  endfunction

  // One clock: check strobes before the edge, advance models, check registers after.
  task automatic step_cycle();
    if (b_live) begin
      en_b   = ($urandom_range(3) != 0);
      hold_b = ($urandom_range(3) == 0);
      rst_b  = ($urandom_range(49) != 0);
    end
    #1;
    tick_seen_a = tick_a;
    check_eq("tick_a", tick_a, mdl_tick(ma, PA, rst_a, en_a));
    check_eq("tick_b", tick_b, mdl_tick(mb, PB, rst_b, en_b));
    @(posedge clk);
    ma = mdl_next(ma, PA, SA, rst_a, en_a, hold_a);
    mb = mdl_next(mb, PB, SB, rst_b, en_b, hold_b);
    #1;
    check_eq("led_a",  led_a,  mdl_led(ma, NA));
    check_eq("mode_a", mode_a, ma.mode);
    check_eq("led_b",  led_b,  mdl_led(mb, NB));
    check_eq("mode_b", mode_b, mb.mode);
    if (mode_b == 3'd4 && LAST_MODE == 3) check_eq("mode_b_no_gap", mode_b, 3);
  endtask

  // Cycles from now until A's first strobe (0 if none within the bound).
  task automatic cycles_to_tick(output int n);
    n = 0;
    for (int i = 1; i <= 16; i++) begin
      step_cycle();
      if (tick_seen_a === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int  n;
    bit  found;
    logic [NA-1:0] led_frz;

    // Reset both instances, then free-run B with random controls.
    step_cycle();
    step_cycle();
    check_eq("reset_mode_a", mode_a, 0);
    check_eq("reset_led_a",  led_a,  0);
    check_eq("reset_mode_b", mode_b, 0);
    b_live = 1'b1;

    // Release with enable: first tick in the 4th cycle, IDLE -> COUNT.
    rst_a = 1'b1;
    en_a  = 1'b1;
    cycles_to_tick(n);
    check_eq("first_tick_cycle", n, 4);
    check_eq("enter_count_mode", mode_a, 1);
    check_eq("enter_count_led",  led_a,  0);

    // One full 48-tick span of uninterrupted sequencing.
    for (int i = 0; i < 48 * PA; i++) step_cycle();
`ifdef LED_SEQ_GAP_EN
    check_eq("loop48_mode", mode_a, 1);
    check_eq("loop48_led",  led_a,  8'h00);
`else
    check_eq("loop48_mode", mode_a, 2);
    check_eq("loop48_led",  led_a,  8'h01);
`endif

    // Hold across the COUNT wrap: mode stays COUNT, step restarts.
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (ma.mode == 1 && ma.step == SA - 1) found = 1;
      else step_cycle();
    end
    check_eq("nav_hold", found, 1);
    hold_a = 1'b1;
    cycles_to_tick(n);
    check_eq("hold_tick_seen", n != 0, 1);
    check_eq("hold_mode", mode_a, 1);
    check_eq("hold_led",  led_a,  8'h00);
    hold_a = 1'b0;

    // Freeze mid-WALK with pre_cnt=2 for 10 cycles.
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (ma.mode == 2 && ma.pre == 2) found = 1;
      else step_cycle();
    end
    check_eq("nav_freeze", found, 1);
    en_a    = 1'b0;
    led_frz = led_a;
    for (int i = 0; i < 10; i++) begin
      step_cycle();
      check_eq("freeze_led",  led_a, led_frz);
      check_eq("freeze_mode", mode_a, 2);
      check_eq("freeze_tick", tick_seen_a, 0);
    end
    en_a = 1'b1;
    step_cycle();
    check_eq("resume_tick0", tick_seen_a, 0);
    step_cycle();
    check_eq("resume_tick1", tick_seen_a, 1);

    // Reset pulse on a BLINK tick cycle.
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (ma.mode == 3 && ma.pre == PA - 1) found = 1;
      else step_cycle();
    end
    check_eq("nav_blink", found, 1);
    rst_a = 1'b0;
    step_cycle();
    check_eq("rst_tick_masked", tick_seen_a, 0);
    check_eq("rst_blink_mode",  mode_a, 0);
    check_eq("rst_blink_led",   led_a,  0);
    rst_a = 1'b1;
    cycles_to_tick(n);
    check_eq("rst_restart_tick", n, 4);

    // Random traffic on A (B is random throughout).
    for (int i = 0; i < 2500; i++) begin
      en_a   = ($urandom_range(9) != 0);
      hold_a = ($urandom_range(4) == 0);
      rst_a  = ($urandom_range(199) != 0);
      step_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1);
  end

endmodule
